// File: rtl/ahblite_irq_ctrl_if.sv
// rtl/ahblite_irq_ctrl_if.sv - AHB-Lite slave bus bundle for the interrupt controller
interface ahblite_irq_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahblite_irq_ctrl.sv
// rtl/ahblite_irq_ctrl.sv - AHB-Lite interrupt controller with per-source edge/level capture
module ahblite_irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahblite_irq_ctrl_if.slave  ahb,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic [NUM_SRC-1:0] irq_out,
  output logic               irq_any
);
  localparam logic [2:0] A_PEND   = 3'd0;
  localparam logic [2:0] A_ENABLE = 3'd1;
  localparam logic [2:0] A_CLEAR  = 3'd2;
  localparam logic [2:0] A_MODE   = 3'd3;
  localparam logic [2:0] A_MASKED = 3'd4;

  logic [NUM_SRC-1:0] pending, enable, mode, src_q;
  logic [NUM_SRC-1:0] wdata, clr, edge_det, pending_nxt;
  logic [2:0]         d_addr;
  logic               d_write, d_valid, wr_en;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign wr_en    = d_valid & d_write & ahb.HREADY;
  assign wdata    = ahb.HWDATA[NUM_SRC-1:0];
  assign clr      = (wr_en && d_addr == A_CLEAR) ? wdata : '0;
  assign edge_det = irq_src & ~src_q;

  // Edge bits latch with set priority over clear; level bits simply track the source.
  assign pending_nxt = (mode & ((pending & ~clr) | edge_det)) | (~mode & irq_src);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
      src_q   <= '0;
      d_addr  <= '0;
      d_write <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      src_q   <= irq_src;
      pending <= pending_nxt;
      if (wr_en && d_addr == A_ENABLE) enable <= wdata;
      if (wr_en && d_addr == A_MODE)   mode   <= wdata;
      if (ahb.HREADY) begin
        d_valid <= ahb.HSEL & ahb.HTRANS[1];
        d_addr  <= ahb.HADDR[4:2];
        d_write <= ahb.HWRITE;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (d_valid && !d_write) begin
      case (d_addr)
        A_PEND:   rdata[NUM_SRC-1:0] = pending;
        A_ENABLE: rdata[NUM_SRC-1:0] = enable;
        A_MODE:   rdata[NUM_SRC-1:0] = mode;
        A_MASKED: rdata[NUM_SRC-1:0] = pending & enable;
        default:  rdata = '0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign irq_out = pending & enable;
  assign irq_any = |irq_out;

  assign unused_ok = ^{ahb.HSIZE, ahb.HPROT, ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HWDATA};
endmodule

// File: tb/tb_ahblite_irq_ctrl.sv
// tb/tb_ahblite_irq_ctrl.sv - self-checking bench for ahblite_irq_ctrl
module tb_ahblite_irq_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  irq_src;
  logic [7:0]  irq_out;
  logic        irq_any;
  logic [31:0] nxt_wdata;
  logic        chk_en;
  int          n_checks = 0;
  int          n_errors = 0;

  ahblite_irq_ctrl_if bus ();

  ahblite_irq_ctrl #(.NUM_SRC(8)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .ahb     (bus.slave),
    .irq_src (irq_src),
    .irq_out (irq_out),
    .irq_any (irq_any)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-source event rules, data phase kept as a byte offset and access kind.
  logic [7:0] m_pend, m_en, m_mode, m_prev;
  int         m_kind;
  int         m_off;

  function automatic logic [7:0] pend_next(input logic [7:0] pend, input logic [7:0] md,
                                           input logic [7:0] src, input logic [7:0] prev,
                                           input logic [7:0] clear);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (md[i]) begin
        if (src[i] && !prev[i]) r[i] = 1'b1;
        else if (clear[i])      r[i] = 1'b0;
        else                    r[i] = pend[i];
      end else begin
        r[i] = src[i];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:       return {24'h0, m_pend};
      4:       return {24'h0, m_en};
      12:      return {24'h0, m_mode};
      16:      return {24'h0, m_pend & m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_pend <= 8'h0; m_en <= 8'h0; m_mode <= 8'h0; m_prev <= 8'h0;
      m_kind <= 0;    m_off <= 0;
    end else begin
      m_pend <= pend_next(m_pend, m_mode, irq_src, m_prev,
                          (m_kind == 2 && bus.HREADY && m_off == 8) ? bus.HWDATA[7:0] : 8'h0);
      if (m_kind == 2 && bus.HREADY && m_off == 4)  m_en   <= bus.HWDATA[7:0];
      if (m_kind == 2 && bus.HREADY && m_off == 12) m_mode <= bus.HWDATA[7:0];
      m_prev <= irq_src;
      if (bus.HREADY) begin
        if (bus.HSEL && bus.HTRANS[1]) begin
          m_kind <= bus.HWRITE ? 2 : 1;
          m_off  <= int'(bus.HADDR[4:2]) * 4;
        end else begin
          m_kind <= 0;
        end
      end
    end
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      check("irq_out",   {24'h0, irq_out}, {24'h0, m_pend & m_en});
      check("irq_any",   {31'h0, irq_any}, {31'h0, |(m_pend & m_en)});
      check("hrdata",    bus.HRDATA, (m_kind == 1) ? model_read(m_off) : 32'h0);
      check("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
      check("hresp",     {31'h0, bus.HRESP}, 32'h0);
    end
  end

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HADDR  = addr;
    bus.HWDATA = nxt_wdata;
    bus.HREADY = 1'b1;
    nxt_wdata  = wdata;
  endtask

  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    drive(sel, trans, wr, addr, wdata);
    @(posedge HCLK); #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    bus_cycle(1'b1, 2'b10, 1'b1, addr, data);
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    bus_cycle(1'b1, 2'b10, 1'b0, addr, 32'h0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge HCLK);
    data = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  initial begin
    vec_t        tbl [17];
    logic [31:0] rd;

    tbl[0]  = '{1'b1, 32'h04, 32'hFFFF_FFFF};
    tbl[1]  = '{1'b0, 32'h04, 32'h0000_00FF};
    tbl[2]  = '{1'b1, 32'h0C, 32'h0000_00A5};
    tbl[3]  = '{1'b0, 32'h0C, 32'h0000_00A5};
    tbl[4]  = '{1'b0, 32'h08, 32'h0};
    tbl[5]  = '{1'b0, 32'h18, 32'h0};
    tbl[6]  = '{1'b1, 32'h08, 32'hFFFF_FFFF};
    tbl[7]  = '{1'b0, 32'h08, 32'h0};
    tbl[8]  = '{1'b1, 32'h14, 32'hFFFF_FFFF};
    tbl[9]  = '{1'b0, 32'h14, 32'h0};
    tbl[10] = '{1'b1, 32'h00, 32'hFFFF_FFFF};
    tbl[11] = '{1'b0, 32'h00, 32'h0};
    tbl[12] = '{1'b1, 32'h10, 32'hFFFF_FFFF};
    tbl[13] = '{1'b0, 32'h10, 32'h0};
    tbl[14] = '{1'b0, 32'h1C, 32'h0};
    tbl[15] = '{1'b1, 32'h0C, 32'h0};
    tbl[16] = '{1'b0, 32'h0C, 32'h0};

    chk_en    = 1'b0;
    HRESETn   = 1'b0;
    irq_src   = 8'h0;
    nxt_wdata = 32'h0;
    bus.HSIZE = 3'b010;
    bus.HPROT = 4'b0011;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge HCLK);
    #1;
    check("reset_irq_out", {24'h0, irq_out}, 32'h0);
    check("reset_irq_any", {31'h0, irq_any}, 32'h0);
    check("reset_hrdata",  bus.HRDATA, 32'h0);
    HRESETn = 1'b1;
    chk_en  = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) write_reg(tbl[i].addr, tbl[i].data);
      else begin
        read_reg(tbl[i].addr, rd);
        check($sformatf("tbl%0d_rd_%02h", i, tbl[i].addr[7:0]), rd, tbl[i].data);
      end
    end

    // Edge capture with enable, then clear.
    write_reg(32'h0C, 32'h01);
    write_reg(32'h04, 32'h01);
    irq_src = 8'h01;
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    irq_src = 8'h00;
    check("edge_irq_out", {24'h0, irq_out}, 32'h1);
    check("edge_irq_any", {31'h0, irq_any}, 32'h1);
    read_reg(32'h00, rd);
    check("edge_pend", rd, 32'h1);
    write_reg(32'h08, 32'h01);
    check("clear_irq_any", {31'h0, irq_any}, 32'h0);
    read_reg(32'h00, rd);
    check("clear_pend", rd, 32'h0);

    // Clear and new edge on the same clock: set wins.
    bus_cycle(1'b1, 2'b10, 1'b1, 32'h08, 32'h01);
    irq_src = 8'h01;
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    irq_src = 8'h00;
    read_reg(32'h00, rd);
    check("collide_pend", rd, 32'h1);
    write_reg(32'h08, 32'h01);

    // Level mode ignores clear while source is high.
    write_reg(32'h0C, 32'h00);
    write_reg(32'h04, 32'h04);
    irq_src = 8'h04;
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    read_reg(32'h00, rd);
    check("level_pend", rd, 32'h4);
    write_reg(32'h08, 32'h04);
    read_reg(32'h00, rd);
    check("level_clear_pend", rd, 32'h4);
    irq_src = 8'h00;
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("level_drop_irq_out", {24'h0, irq_out}, 32'h0);
    read_reg(32'h00, rd);
    check("level_drop_pend", rd, 32'h0);

    // Disabled source still records; enable exposes it without a new event.
    write_reg(32'h04, 32'h00);
    write_reg(32'h0C, 32'h08);
    irq_src = 8'h08;
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    irq_src = 8'h00;
    read_reg(32'h00, rd);
    check("mask_pend", rd, 32'h8);
    read_reg(32'h10, rd);
    check("mask_masked", rd, 32'h0);
    check("mask_irq_any", {31'h0, irq_any}, 32'h0);
    bus_cycle(1'b1, 2'b10, 1'b1, 32'h04, 32'h08);
    bus_cycle(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("unmask_irq_out", {24'h0, irq_out}, 32'h8);

    // Reset in the data phase of an ENABLE write.
    bus_cycle(1'b1, 2'b10, 1'b1, 32'h04, 32'hFF);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    check("rst_mid_irq_any", {31'h0, irq_any}, 32'h0);
    check("rst_mid_irq_out", {24'h0, irq_out}, 32'h0);
    irq_src   = 8'h02;
    nxt_wdata = 32'h0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    read_reg(32'h04, rd);
    check("rst_enable", rd, 32'h0);
    read_reg(32'h00, rd);
    check("rst_first_edge_pend", rd, 32'h2);
    read_reg(32'h0C, rd);
    check("rst_mode", rd, 32'h0);
    irq_src = 8'h00;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      irq_src = 8'($urandom);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
            32'($urandom_range(0, 7)) << 2, $urandom);
      bus.HREADY = ($urandom_range(0, 7) != 0);
      bus.HSIZE  = 3'($urandom);
      bus.HPROT  = 4'($urandom);
      @(posedge HCLK); #1;
    end
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge HCLK); #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ahblite_irq_ctrl.md
AHBLITE_IRQ_CTRL -- requirements
Module: ahblite_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, 8, number of interrupt sources; legal range 1..32.
REQ-002 HCLK  input  1  AHB clock; all state updates on rising edge.
REQ-003 HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 HSEL  input  1  slave select.
REQ-005 HADDR  input  32  address; only HADDR[4:2] decoded.
REQ-006 HTRANS  input  2  transfer type; HTRANS[1]=1 marks a valid transfer.
REQ-007 HSIZE  input  3  ignored; all accesses are treated as 32-bit.
REQ-008 HPROT  input  4  ignored.
REQ-009 HWRITE  input  1  1=write, 0=read.
REQ-010 HWDATA  input  32  write data, valid in data phase.
REQ-011 HREADY  input  1  bus ready.
REQ-012 HREADYOUT  output  1  tied 1; zero wait states.
REQ-013 HRDATA  output  32  read data, driven in data phase.
REQ-014 HRESP  output  1  tied 0; OKAY only.
REQ-015 irq_src  input  NUM_SRC  interrupt sources, synchronous to HCLK; bit 0 carries the timer's timer_irq single-cycle pulse.
REQ-016 irq_out  output  NUM_SRC  per-source pending AND enable.
REQ-017 irq_any  output  1  OR-reduction of irq_out.

Function
REQ-018 Address phase: when HSEL & HREADY & HTRANS[1], the block SHALL register HADDR[4:2], HWRITE and a valid flag for the following data phase.
REQ-019 Register map:
- 0x00 PEND: RO; pending bits.
- 0x04 ENABLE: RW.
- 0x08 CLEAR: WO, write-1-to-clear pending; reads 0.
- 0x0C MODE: RW; 1=rising-edge, 0=level.
- 0x10 MASKED: RO; pending & enable.
- 0x14-0x1C: read 0; writes ignored.
REQ-020 Writes SHALL take effect at the rising edge ending the data phase (valid write flag & HREADY), using HWDATA[NUM_SRC-1:0]; upper bits ignored.
REQ-021 HRDATA SHALL be combinational from the registered address and current register state; bits [31:NUM_SRC] read 0; HRDATA is 0 when no valid read data phase is active.
REQ-022 Writes to RO offsets (0x00, 0x10) SHALL have no effect.
REQ-023 src_q SHALL register irq_src every cycle, regardless of mode.
REQ-024 Edge mode, bit i: edge = irq_src[i] & ~src_q[i]; pending[i] SHALL set at the next edge when edge=1, independent of ENABLE.
REQ-025 Edge mode: pending[i] SHALL hold until cleared by a CLEAR write.
REQ-026 Edge mode: set and clear on the same edge SHALL leave pending[i]=1 (set wins).
REQ-027 Edge mode: an irq_src[i] held high SHALL produce exactly one set.
REQ-028 Level mode, bit i: pending[i] SHALL load irq_src[i] every cycle; CLEAR writes have no lasting effect.
REQ-029 Mode change SHALL NOT alter pending immediately. After a level-to-edge switch, pending keeps its last value until cleared or re-set.
REQ-030 Latency: irq_src rising before edge N SHALL appear on irq_out/irq_any after edge N (1 cycle).
REQ-031 Latency: an ENABLE write SHALL gate irq_out immediately after its data-phase edge.
REQ-032 irq_out and irq_any SHALL be combinational from registered pending/enable; no combinational path from irq_src or AHB inputs.
REQ-033 Disabled sources SHALL still record pending; enabling later SHALL assert irq_out with no new event.

Reset
REQ-034 On HRESETn low, asynchronously:
- pending, ENABLE, MODE (all level) SHALL be 0.
- src_q SHALL be 0.
- registered address/valid/write flags SHALL be 0.
- irq_out and irq_any SHALL be 0.
REQ-035 First edge after reset release: an irq_src bit already high SHALL count as a rising edge in edge mode.
REQ-036 Reset mid-transfer SHALL abort the pending write with no register change.

Verification
REQ-037 Enable+edge: write MODE=0x01, ENABLE=0x01; 1-cycle pulse on irq_src[0] -> PEND=0x01, irq_out=0x01, irq_any=1 one cycle after the pulse; write CLEAR=0x01 -> PEND=0x00, irq_any=0.
REQ-038 Set/clear collision: edge mode bit 0; CLEAR=0x01 data-phase edge coincides with a new irq_src[0] rising edge -> PEND reads 0x01.
REQ-039 Level mode: MODE=0x00, ENABLE=0x04; hold irq_src[2]=1 -> PEND=0x04; write CLEAR=0x04 -> PEND still 0x04; drop irq_src[2] -> PEND=0x00 next cycle.
REQ-040 Masking: ENABLE=0, edge pulse on bit 3 -> PEND=0x08, MASKED=0x00, irq_any=0; write ENABLE=0x08 -> irq_out=0x08 immediately after that edge.
REQ-041 Register access: write ENABLE=0xFFFFFFFF with NUM_SRC=8 -> reads 0x000000FF; read 0x08 and 0x18 -> 0; HREADYOUT=1, HRESP=0 throughout.
REQ-042 Reset: assert HRESETn mid write data phase to ENABLE -> all registers 0, irq_any=0; irq_src[1] high at release in edge mode -> PEND=0x02 after first edge.
